valet_tip_emitter: RTL and testbench

VALET_TIP_EMITTER -- requirements
Module: valet_tip_emitter

---
 rtl/valet_pkg.sv | 54 +++++
 rtl/retrieval_timer.sv | 27 ++
 rtl/valet_tip_emitter.sv | 181 ++++++++++++++++++
 tb/tb_valet_tip_emitter.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/valet_pkg.sv
// Shared types and constants for the valet tip emitter: event classes, FSM states,
// tip amounts and the retrieval-time classifier.
package valet_pkg;

    typedef enum logic [1:0] {
        TIP_NONE    = 2'b00,
        TIP_REWARD  = 2'b01,
        TIP_PENALTY = 2'b10,
        TIP_BONUS   = 2'b11
    } tip_event_t;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_TIMING   = 2'b01,
        ST_CLASSIFY = 2'b10,
        ST_EMIT     = 2'b11
    } valet_state_t;

    localparam logic signed [15:0] TIP_BONUS_AMT   = 16'sd25;
    localparam logic signed [15:0] TIP_REWARD_AMT  = 16'sd10;
    localparam logic signed [15:0] TIP_PENALTY_AMT = -16'sd10;

    typedef struct packed {
        tip_event_t         kind;
        logic signed [15:0] delta;
    } tip_result_t;

    // Earlier thresholds win: a time that is both <= bonus and >= slow is a bonus.
    function automatic tip_result_t classify_tip(
        input logic [31:0] t,
        input logic [31:0] bonus_cycles,
        input logic [31:0] fast_cycles,
        input logic [31:0] slow_cycles
    );
        tip_result_t r;
        r.kind  = TIP_NONE;
        r.delta = 16'sd0;
        if (t <= bonus_cycles) begin
            r.kind  = TIP_BONUS;
            r.delta = TIP_BONUS_AMT;
        end else if (t <= fast_cycles) begin
            r.kind  = TIP_REWARD;
            r.delta = TIP_REWARD_AMT;
        end else if (t >= slow_cycles) begin
            r.kind  = TIP_PENALTY;
            r.delta = TIP_PENALTY_AMT;
        end else begin
            r.kind  = TIP_NONE;
            r.delta = 16'sd0;
        end
        return r;
    endfunction

endpackage

// File: rtl/retrieval_timer.sv
// Saturating 32-bit cycle counter with synchronous clear and count enable.
module retrieval_timer (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        en,
    output logic [31:0] count
);

    logic [31:0] count_r;

    // Counter register: clear has priority, then count until all-ones and stick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= 32'd0;
        end else if (clr) begin
            count_r <= 32'd0;
        end else if (en && (count_r != 32'hFFFF_FFFF)) begin
            count_r <= count_r + 32'd1;
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/valet_tip_emitter.sv
// Measures valet retrieval time and emits one classified tip event per retrieval
// over a valid/ready handshake. Define VALET_TIP_STATS_EN to enable evt_count.
module valet_tip_emitter
    import valet_pkg::*;
#(
    parameter logic [31:0] BONUS_CYCLES = 32'd50,
    parameter logic [31:0] FAST_CYCLES  = 32'd100,
    parameter logic [31:0] SLOW_CYCLES  = 32'd400
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_start,
    input  logic               req_done,
    input  logic               req_abort,
    output logic               evt_valid,
    input  logic               evt_ready,
    output logic signed [15:0] tip_delta_out,
    output tip_event_t         tip_event_type_out,
    output logic [31:0]        retrieval_time_out,
    output logic               busy,
    output logic [7:0]         dropped_cnt,
    output logic [15:0]        evt_count
);

    valet_state_t       state_r;
    valet_state_t       state_s;
    logic               timer_clr_s;
    logic               timer_en_s;
    logic [31:0]        time_s;
    logic               handshake_s;
    tip_result_t        cls_s;

    logic               abort_r;
    logic               evt_valid_r;
    logic signed [15:0] tip_delta_r;
    tip_event_t         tip_type_r;
    logic [31:0]        time_r;
    logic               busy_r;
    logic [7:0]         dropped_r;

    retrieval_timer u_timer (
        .clk   (clk),
        .rst   (rst),
        .clr   (timer_clr_s),
        .en    (timer_en_s),
        .count (time_s)
    );

    assign handshake_s = evt_valid_r && evt_ready;
    assign cls_s       = classify_tip(time_r, BONUS_CYCLES, FAST_CYCLES, SLOW_CYCLES);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state and timer control; the timer also counts on the done/abort edge.
    always_comb begin
        state_s     = state_r;
        timer_clr_s = 1'b0;
        timer_en_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (req_start) begin
                    state_s     = ST_TIMING;
                    timer_clr_s = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_TIMING: begin
                timer_en_s = 1'b1;
                if (req_done || req_abort) begin
                    state_s = ST_CLASSIFY;
                end else begin
                    state_s = ST_TIMING;
                end
            end
            ST_CLASSIFY: state_s = ST_EMIT;
            ST_EMIT: begin
                if (handshake_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_EMIT;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Event payload: latch abort at end of timing, classify the captured time, hold until accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            abort_r     <= 1'b0;
            evt_valid_r <= 1'b0;
            tip_delta_r <= 16'sd0;
            tip_type_r  <= TIP_NONE;
            time_r      <= 32'd0;
        end else begin
            case (state_r)
                ST_TIMING: begin
                    abort_r <= req_abort && !req_done;
                    time_r  <= 32'd0;
                end
                ST_CLASSIFY: begin
                    evt_valid_r <= 1'b1;
                    time_r      <= time_s;
                    if (abort_r) begin
                        tip_type_r  <= TIP_NONE;
                        tip_delta_r <= 16'sd0;
                    end else begin
                        tip_type_r  <= classify_tip(time_s, BONUS_CYCLES, FAST_CYCLES, SLOW_CYCLES).kind;
                        tip_delta_r <= classify_tip(time_s, BONUS_CYCLES, FAST_CYCLES, SLOW_CYCLES).delta;
                    end
                end
                ST_EMIT: begin
                    if (handshake_s) begin
                        evt_valid_r <= 1'b0;
                        tip_delta_r <= 16'sd0;
                        tip_type_r  <= TIP_NONE;
                        time_r      <= 32'd0;
                    end else begin
                        evt_valid_r <= evt_valid_r;
                    end
                end
                default: begin
                    evt_valid_r <= 1'b0;
                    tip_delta_r <= 16'sd0;
                    tip_type_r  <= TIP_NONE;
                    time_r      <= 32'd0;
                end
            endcase
        end
    end

    // Registered busy flag and saturating count of start pulses seen outside IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_r    <= 1'b0;
            dropped_r <= 8'd0;
        end else begin
            busy_r <= (state_s != ST_IDLE);
            if (req_start && (state_r != ST_IDLE) && (dropped_r != 8'hFF)) begin
                dropped_r <= dropped_r + 8'd1;
            end else begin
                dropped_r <= dropped_r;
            end
        end
    end

`ifdef VALET_TIP_STATS_EN
    logic [15:0] evt_count_r;

    // Saturating count of accepted events.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            evt_count_r <= 16'd0;
        end else if (handshake_s && (evt_count_r != 16'hFFFF)) begin
            evt_count_r <= evt_count_r + 16'd1;
        end else begin
            evt_count_r <= evt_count_r;
        end
    end

    assign evt_count = evt_count_r;
`else
    assign evt_count = 16'd0;
`endif

    assign evt_valid          = evt_valid_r;
    assign tip_delta_out      = tip_delta_r;
    assign tip_event_type_out = tip_type_r;
    assign retrieval_time_out = time_r;
    assign busy               = busy_r;
    assign dropped_cnt        = dropped_r;

endmodule

// File: tb/tb_valet_tip_emitter.sv
// Directed self-checking bench for valet_tip_emitter with hand-computed expectations.
module tb_valet_tip_emitter;
    import valet_pkg::*;

    logic               clk = 1'b0;
    logic               rst;
    logic               req_start, req_done, req_abort, evt_ready;
    logic               evt_valid, busy;
    logic signed [15:0] tip_delta_out;
    tip_event_t         tip_event_type_out;
    logic [31:0]        retrieval_time_out;
    logic [7:0]         dropped_cnt;
    logic [15:0]        evt_count;

    int tests = 0;
    int fails = 0;
    int hs_cnt = 0;

`ifdef VALET_TIP_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    valet_tip_emitter dut (
        .clk                (clk),
        .rst                (rst),
        .req_start          (req_start),
        .req_done           (req_done),
        .req_abort          (req_abort),
        .evt_valid          (evt_valid),
        .evt_ready          (evt_ready),
        .tip_delta_out      (tip_delta_out),
        .tip_event_type_out (tip_event_type_out),
        .retrieval_time_out (retrieval_time_out),
        .busy               (busy),
        .dropped_cnt        (dropped_cnt),
        .evt_count          (evt_count)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Start, wait n cycles, end with done and/or abort, then step into EMIT.
    task automatic retrieve(input int n, input bit abort_en, input bit done_en);
        req_start = 1'b1;
        tick();
        req_start = 1'b0;
        repeat (n - 1) tick();
        req_done  = done_en;
        req_abort = abort_en;
        tick();
        req_done  = 1'b0;
        req_abort = 1'b0;
        tick();
    endtask

    task automatic check_evt(input string tag, input tip_event_t k, input logic signed [15:0] d,
                             input logic [31:0] t);
        check({tag, "_valid"}, 32'(evt_valid), 32'd1);
        check({tag, "_type"}, 32'(tip_event_type_out), 32'(k));
        check({tag, "_delta"}, 32'(tip_delta_out), 32'(d));
        check({tag, "_time"}, retrieval_time_out, t);
    endtask

    task automatic accept;
        tick();
        hs_cnt++;
    endtask

    initial begin
        rst = 1'b1; req_start = 1'b0; req_done = 1'b0; req_abort = 1'b0; evt_ready = 1'b1;
        #1;
        check("rst_valid", 32'(evt_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_time", retrieval_time_out, 32'd0);
        check("rst_dropped", 32'(dropped_cnt), 32'd0);
        check("rst_cnt", 32'(evt_count), 32'd0);
        repeat (2) tick();
        rst = 1'b0;
        tick();

        // Bonus: done 40 cycles after start, valid 2 cycles after done, idle one later.
        req_start = 1'b1; tick(); req_start = 1'b0;
        check("t1_busy", 32'(busy), 32'd1);
        repeat (39) tick();
        req_done = 1'b1; tick(); req_done = 1'b0;
        check("t1_valid_early", 32'(evt_valid), 32'd0);
        tick();
        check_evt("t1", TIP_BONUS, 16'sd25, 32'd40);
        accept();
        check("t1_valid_after", 32'(evt_valid), 32'd0);
        check("t1_busy_after", 32'(busy), 32'd0);
        check("t1_delta_after", 32'(tip_delta_out), 32'd0);
        check("t1_time_after", retrieval_time_out, 32'd0);

        retrieve(250, 1'b0, 1'b1);
        check_evt("t2", TIP_NONE, 16'sd0, 32'd250);
        accept();
        retrieve(500, 1'b0, 1'b1);
        check_evt("t3", TIP_PENALTY, -16'sd10, 32'd500);
        accept();

        // Reward with back-pressure: payload held while ready is low.
        evt_ready = 1'b0;
        retrieve(80, 1'b0, 1'b1);
        check_evt("t4", TIP_REWARD, 16'sd10, 32'd80);
        for (int i = 0; i < 4; i++) begin
            tick();
            check_evt("t4_hold", TIP_REWARD, 16'sd10, 32'd80);
        end
        evt_ready = 1'b1;
        accept();
        check("t4_valid_after", 32'(evt_valid), 32'd0);
        tick();
        check("t4_single", 32'(evt_valid), 32'd0);
        check("t4_cnt", 32'(evt_count), STATS ? 32'(hs_cnt) : 32'd0);

        // Abort at 30 would be a bonus if classified; it must report none.
        retrieve(30, 1'b1, 1'b0);
        check_evt("t5", TIP_NONE, 16'sd0, 32'd30);
        accept();

        // Three start pulses during timing are dropped and do not restart the timer.
        req_start = 1'b1; tick(); req_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            req_start = 1'b1; tick(); req_start = 1'b0; tick();
        end
        repeat (53) tick();
        req_done = 1'b1; tick(); req_done = 1'b0;
        tick();
        check_evt("t6", TIP_REWARD, 16'sd10, 32'd60);
        check("t6_dropped", 32'(dropped_cnt), 32'd3);
        req_start = 1'b1; accept(); req_start = 1'b0;
        check("t6_hs_start_busy", 32'(busy), 32'd0);
        check("t6_hs_start_dropped", 32'(dropped_cnt), 32'd4);
        tick();
        check("t6_still_idle", 32'(busy), 32'd0);

        // Done and abort together count as done.
        retrieve(45, 1'b1, 1'b1);
        check_evt("t7", TIP_BONUS, 16'sd25, 32'd45);
        accept();

        // Start and done together in IDLE: start wins, done ignored.
        req_start = 1'b1; req_done = 1'b1; tick(); req_start = 1'b0; req_done = 1'b0;
        check("t8_busy", 32'(busy), 32'd1);
        repeat (19) tick();
        req_done = 1'b1; tick(); req_done = 1'b0;
        tick();
        check_evt("t8", TIP_BONUS, 16'sd25, 32'd20);
        accept();

        // Reset during timing.
        req_start = 1'b1; tick(); req_start = 1'b0;
        repeat (10) tick();
        rst = 1'b1; #1;
        check("t9_rst_busy", 32'(busy), 32'd0);
        check("t9_rst_dropped", 32'(dropped_cnt), 32'd0);
        hs_cnt = 0;
        tick(); rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t9_no_evt", 32'(evt_valid) | 32'(busy), 32'd0);
        end

        // Reset while an event is pending.
        evt_ready = 1'b0;
        retrieve(70, 1'b0, 1'b1);
        check_evt("t10_pre", TIP_REWARD, 16'sd10, 32'd70);
        rst = 1'b1; #1;
        check("t10_rst_valid", 32'(evt_valid), 32'd0);
        check("t10_rst_delta", 32'(tip_delta_out), 32'd0);
        check("t10_rst_type", 32'(tip_event_type_out), 32'd0);
        check("t10_rst_time", retrieval_time_out, 32'd0);
        check("t10_rst_busy", 32'(busy), 32'd0);
        tick(); rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t10_no_evt", 32'(evt_valid), 32'd0);
        end
        evt_ready = 1'b1;
        retrieve(120, 1'b0, 1'b1);
        check_evt("t10_next", TIP_NONE, 16'sd0, 32'd120);
        accept();
        check("t10_cnt", 32'(evt_count), STATS ? 32'(hs_cnt) : 32'd0);

        // Timer preset near all-ones must stick at saturation and classify as penalty.
        req_start = 1'b1; tick(); req_start = 1'b0;
        force dut.u_timer.count_r = 32'hFFFF_FFFD;
        #1;
        release dut.u_timer.count_r;
        repeat (4) tick();
        req_done = 1'b1; tick(); req_done = 1'b0;
        tick();
        check_evt("t11_sat", TIP_PENALTY, -16'sd10, 32'hFFFF_FFFF);
        accept();
        check("t11_valid_after", 32'(evt_valid), 32'd0);
        check("final_cnt", 32'(evt_count), STATS ? 32'(hs_cnt) : 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
